// File: rtl/memory_r2_mib_writer.sv
// ---------------------------------------------------------------------------
// memory_r2_mib_writer
//
// Write-side controller for the r2 upper tank. It keeps a free-running copy
// of the tank circulation position (digit slot within a minor cycle, and
// minor cycle within the tank). It accepts one parallel word at a time and
// waits for the addressed minor cycle to come round. It then shifts the word
// out LSB-first on r2_mib, with the tank input gate and recirculation clear
// held high for the whole word window.
//
// Ports
//   r2_clk        digit clock, one cycle per digit period
//   r2_rst        synchronous active-high reset
//   r2_wr_req     write request, only looked at while idle
//   r2_wr_addr    minor-cycle address of the word (bit 0 ignored for long)
//   r2_wr_long    1 = 35-bit long word spanning two minor cycles
//   r2_wr_data    word to write, short words use [16:0]
//   r2_busy       high from the cycle after acceptance through the ack cycle
//   r2_wr_ack     single-cycle completion pulse
//   r2_mib        serial data into the tank
//   r2_up_t2_in   tank input gate
//   r2_up_t2_clr  tank recirculation clear
//   r2_pos_bit    current digit slot, 0..BITS_PER_MINOR-1
//   r2_pos_minor  current minor cycle, 0..MINORS_PER_TANK-1
//   r2_sync       high when the position is (0,0)
// ---------------------------------------------------------------------------
module memory_r2_mib_writer #(
    parameter int BITS_PER_MINOR  = 18,
    parameter int MINORS_PER_TANK = 32,
    parameter int SHORT_BITS      = 17,
    parameter int LONG_BITS       = 35
) (
    input  logic                 r2_clk,
    input  logic                 r2_rst,
    input  logic                 r2_wr_req,
    input  logic [4:0]           r2_wr_addr,
    input  logic                 r2_wr_long,
    input  logic [LONG_BITS-1:0] r2_wr_data,
    output logic                 r2_busy,
    output logic                 r2_wr_ack,
    output logic                 r2_mib,
    output logic                 r2_up_t2_in,
    output logic                 r2_up_t2_clr,
    output logic [4:0]           r2_pos_bit,
    output logic [4:0]           r2_pos_minor,
    output logic                 r2_sync
);

    // Two minor cycles of slots; the top slot is the long-word gap and the
    // short-word gap (slot 17) is cleared at capture, so both read as 0.
    localparam int          DATA_W     = 2 * BITS_PER_MINOR;
    localparam logic [4:0]  BIT_LAST   = 5'(BITS_PER_MINOR - 1);
    localparam logic [4:0]  MINOR_LAST = 5'(MINORS_PER_TANK - 1);
    localparam logic [5:0]  SLOT_OFS   = 6'(BITS_PER_MINOR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [4:0]          pos_bit_reg, pos_bit_next;
    logic [4:0]          pos_minor_reg, pos_minor_next;
    logic [4:0]          addr_reg, addr_next;
    logic                long_reg, long_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                mib_reg, mib_next;
    logic                t2_in_reg, t2_in_next;
    logic                t2_clr_reg, t2_clr_next;

    logic                accept;
    logic                bit_wrap;
    logic                target_hit;
    logic                last_slot;
    logic [4:0]          capture_addr;
    logic [DATA_W-1:0]   capture_data;
    logic [5:0]          slot_next;

    // -----------------------------------------------------------------------
    // Capture path: mask the incoming word to its length so every slot past
    // the last data bit (including both gap slots) shifts out as 0.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_capture
            if (gi < SHORT_BITS) begin : g_short
                assign capture_data[gi] = r2_wr_data[gi];
            end else if (gi < LONG_BITS) begin : g_long
                assign capture_data[gi] = r2_wr_data[gi] & r2_wr_long;
            end else begin : g_gap
                assign capture_data[gi] = 1'b0;
            end
        end
    endgenerate

    // Long words occupy an even/odd minor-cycle pair.
    assign capture_addr = {r2_wr_addr[4:1], r2_wr_addr[0] & ~r2_wr_long};
    assign accept       = (state_reg == ST_IDLE) && r2_wr_req;

    // -----------------------------------------------------------------------
    // Position counters (free-running in every state)
    // -----------------------------------------------------------------------
    always_comb begin
        bit_wrap       = (pos_bit_reg == BIT_LAST);
        pos_bit_next   = bit_wrap ? 5'd0 : pos_bit_reg + 5'd1;
        pos_minor_next = pos_minor_reg;
        if (bit_wrap) begin
            pos_minor_next = (pos_minor_reg == MINOR_LAST) ? 5'd0
                                                           : pos_minor_reg + 5'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Captured request
    // -----------------------------------------------------------------------
    always_comb begin
        addr_next = addr_reg;
        long_next = long_reg;
        data_next = data_reg;
        if (accept) begin
            addr_next = capture_addr;
            long_next = r2_wr_long;
            data_next = capture_data;
        end
    end

    // The window starts when the *next* position is (addr,0). Looking one
    // cycle ahead keeps the registered serial outputs aligned with the
    // position outputs, and naturally excludes the acceptance cycle itself
    // (acceptance at (addr,0) waits a full circulation).
    assign target_hit = (pos_bit_next == 5'd0) && (pos_minor_next == addr_next);

    // Final slot of the window: gap of the only (short) or second (long) minor.
    assign last_slot = (pos_bit_reg == BIT_LAST) &&
                       (!long_reg || (pos_minor_reg != addr_reg));

    // Slot index within the word for the next cycle.
    assign slot_next = {1'b0, pos_bit_next} +
                       ((long_next && (pos_minor_next != addr_next)) ? SLOT_OFS : 6'd0);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge r2_clk) begin
        if (r2_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (r2_wr_req) begin
                    state_next = target_hit ? ST_SHIFT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (target_hit) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_slot) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        r2_busy   = (state_reg != ST_IDLE);
        r2_wr_ack = (state_reg == ST_DONE);
    end

    // Serial-side values for the next cycle, registered below.
    always_comb begin
        t2_in_next  = (state_next == ST_SHIFT);
        t2_clr_next = (state_next == ST_SHIFT);
        mib_next    = (state_next == ST_SHIFT) && data_next[slot_next];
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge r2_clk) begin
        if (r2_rst) begin
            pos_bit_reg   <= 5'd0;
            pos_minor_reg <= 5'd0;
            addr_reg      <= 5'd0;
            long_reg      <= 1'b0;
            data_reg      <= '0;
            mib_reg       <= 1'b0;
            t2_in_reg     <= 1'b0;
            t2_clr_reg    <= 1'b0;
        end else begin
            pos_bit_reg   <= pos_bit_next;
            pos_minor_reg <= pos_minor_next;
            addr_reg      <= addr_next;
            long_reg      <= long_next;
            data_reg      <= data_next;
            mib_reg       <= mib_next;
            t2_in_reg     <= t2_in_next;
            t2_clr_reg    <= t2_clr_next;
        end
    end

    assign r2_mib       = mib_reg;
    assign r2_up_t2_in  = t2_in_reg;
    assign r2_up_t2_clr = t2_clr_reg;
    assign r2_pos_bit   = pos_bit_reg;
    assign r2_pos_minor = pos_minor_reg;
    assign r2_sync      = (pos_bit_reg == 5'd0) && (pos_minor_reg == 5'd0);

endmodule

// File: doc/memory_r2_mib_writer.md
Name: memory_r2_mib_writer

Overview:
- Write-side controller for the r2 upper tank, on the driving end of the mib / t2_in / t2_clr interface that the tank consumes.
- Tracks tank circulation position with digit and minor-cycle counters.
- Accepts a parallel short (17-bit) or long (35-bit) word with an address, waits for the addressed minor cycle, then serialises the word LSB-first onto r2_mib with in/clr strobes asserted.
- Exports position so the read side and the monitor can align to the same timing.

Parameters:
- BITS_PER_MINOR, 18, digit periods per minor cycle (17 data + 1 gap).
- MINORS_PER_TANK, 32, minor cycles per tank circulation (576 digit periods total).
- SHORT_BITS, 17, data bits in a short word.
- LONG_BITS, 35, data bits in a long word.

Ports:
- r2_clk  in  1  digit clock; one cycle = one digit period.
- r2_rst  in  1  synchronous, active-high reset.
- r2_wr_req  in  1  write request; sampled only in IDLE.
- r2_wr_addr  in  5  short-word address (minor cycle index).
- r2_wr_long  in  1  1 = long word; addr[0] forced to 0.
- r2_wr_data  in  35  word to write; short uses [16:0].
- r2_busy  out  1  high from the cycle after acceptance through the ack cycle.
- r2_wr_ack  out  1  one-cycle pulse when the write completes.
- r2_mib  out  1  serial data to tank.
- r2_up_t2_in  out  1  tank input gate.
- r2_up_t2_clr  out  1  tank recirculation clear.
- r2_pos_bit  out  5  current digit slot, 0..17.
- r2_pos_minor  out  5  current minor cycle, 0..31.
- r2_sync  out  1  high when pos = (0,0).

Behaviour:
- Reset (synchronous, r2_rst high at an edge):
  - pos_bit=0, pos_minor=0, state=IDLE.
  - r2_busy, r2_wr_ack, r2_mib, r2_up_t2_in, r2_up_t2_clr all 0.
  - r2_sync=1, since position is (0,0).
  - Reset has priority over all other activity.
- Position counters:
  - pos_bit increments every cycle and wraps 17→0.
  - pos_minor increments when pos_bit wraps; it wraps 31→0.
  - Counters free-run in every state.
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE:
  - If r2_wr_req=1, capture addr (addr[0]=0 when long), the long flag, and data; go to WAIT.
  - busy rises the next cycle.
- WAIT: stay until the word window begins.
  - The window is the first cycle, strictly after the acceptance cycle, in which position = (addr, 0).
  - Latency from acceptance to first data digit: 1..576 cycles.
  - Acceptance in the cycle where position = (addr-1 mod 32, 17) gives latency 1.
  - Acceptance in the cycle where position = (addr, 0) gives latency 576.
- SHIFT:
  - Short word spans 18 slots; long word spans 36 slots (minor cycles addr and addr+1).
  - In slot k (k = pos_bit, or pos_bit+18 in the second minor cycle of a long word), r2_mib = data[k] for k < SHORT_BITS (short) or k < LONG_BITS (long); the gap slot (17 short, 35 long) drives 0.
  - r2_up_t2_in and r2_up_t2_clr are both 1 in every slot of the window and 0 everywhere else.
  - r2_mib is 0 outside the window.
  - Outputs are registered but aligned to the position outputs of the same cycle.
- DONE:
  - Entered the cycle after the last window slot.
  - r2_wr_ack=1 for exactly that one cycle; busy is still 1.
  - Next state is IDLE; busy=0.
- Requests outside IDLE (WAIT/SHIFT/DONE) are ignored; no queueing.
- If r2_wr_req is held high continuously, the next write is accepted in the first IDLE cycle after DONE.
- Long word at addr 30 uses minor cycles 30 and 31. No wrap to minor 0 can occur, because addr[0] is forced to 0.
- Reset asserted during SHIFT:
  - in/clr/mib are 0 from the next edge.
  - No ack is issued; captured data is discarded.
- Input data changes after acceptance have no effect (data is captured).

Test Plan:
1. Reset then run 576 cycles → r2_sync pulses at cycle 0 and again at cycle 576; pos_minor reaches 31 at cycle 558; all write outputs stay 0.
2. Short write, addr=5, data=17'h1_5555, req at position (0,0) → window at (5,0)..(5,17); mib = 1,0,1,0,…,1 on bits 0..16, then 0 at slot 17; in/clr high for 18 cycles; ack at (6,0); busy low at (6,1).
3. Long write, addr=7 (forced to 6), data=35'h4_0000_0001 → window covers minor cycles 6–7 (36 slots); mib=1 at (6,0) and (7,16), 0 elsewhere; ack at (8,0).
4. Accept at position (9,0) with addr=9 → no window in this circulation; first data digit at cycle +576; ack at (10,0) of the next circulation.
5. req held high with a second request issued during SHIFT → second request ignored; only one ack; a new acceptance occurs the cycle after DONE.
6. Long write, addr=30, reset asserted at (31,3) → in/clr/mib 0 from the next cycle; no ack; counters restart at (0,0); busy 0.
